// File: rtl/cross_bar_router_1xn.sv
// cross_bar_router_1xn
// Routes packets from one AXI-Stream slave port to one of CHANNEL_NO master
// ports. The destination is captured from the first beat of each packet and
// the whole packet follows it. A single holding register drives all outputs.
// Packets addressed past the last channel are discarded and counted.
module cross_bar_router_1xn #(
    parameter int DSEL_WIDTH = 2,
    parameter int CHANNEL_NO = 2**DSEL_WIDTH,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  aclk,
    input  logic                  areset,

    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [DSEL_WIDTH-1:0] s_axis_tdest,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,

    output logic [DATA_WIDTH-1:0] m_axis_tdata [CHANNEL_NO],
    output logic [CHANNEL_NO-1:0] m_axis_tvalid,
    output logic [CHANNEL_NO-1:0] m_axis_tlast,
    input  logic [CHANNEL_NO-1:0] m_axis_tready,

    output logic [CNT_WIDTH-1:0]  drop_count
);

    // One spare bit so that CHANNEL_NO == 2**DSEL_WIDTH is representable.
    localparam logic [DSEL_WIDTH:0] CH_LIMIT = (DSEL_WIDTH + 1)'(CHANNEL_NO);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ROUTE = 2'b01,
        DROP  = 2'b10
    } state_t;

    state_t                  state;
    state_t                  state_next;

    logic [DSEL_WIDTH-1:0]   pkt_dest;
    logic                    out_valid;
    logic [DATA_WIDTH-1:0]   out_data;
    logic                    out_last;
    logic [DSEL_WIDTH-1:0]   out_dest;

    logic                    sel_ready;
    logic                    s_hs;
    logic                    load;
    logic                    drain;
    logic                    drop_done;

    // A destination is routable only if it names an existing output.
    function automatic logic dest_legal(input logic [DSEL_WIDTH-1:0] dest);
        return ({1'b0, dest} < CH_LIMIT);
    endfunction

    // Drop counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt);
        return (cnt == {CNT_WIDTH{1'b1}}) ? cnt : cnt + CNT_WIDTH'(1);
    endfunction

    // Ready of the output currently addressed by the holding register.
    always_comb begin
        sel_ready = 1'b0;
        for (int i = 0; i < CHANNEL_NO; i++) begin
            if (out_dest == DSEL_WIDTH'(i)) begin
                sel_ready = m_axis_tready[i];
            end
        end
    end

    // FSM state register; an illegal encoding falls back to IDLE via next-state logic.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state: IDLE classifies the packet, ROUTE/DROP run until the tlast beat.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (s_axis_tvalid) begin
                    state_next = dest_legal(s_axis_tdest) ? ROUTE : DROP;
                end
            end
            ROUTE: begin
                if (s_hs && s_axis_tlast) begin
                    state_next = IDLE;
                end
            end
            DROP: begin
                if (s_hs && s_axis_tlast) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM outputs: IDLE never consumes a beat, ROUTE waits for room, DROP sinks everything.
    always_comb begin
        s_axis_tready = 1'b0;
        case (state)
            IDLE:    s_axis_tready = 1'b0;
            ROUTE:   s_axis_tready = !out_valid || sel_ready;
            DROP:    s_axis_tready = 1'b1;
            default: s_axis_tready = 1'b0;
        endcase
        s_hs      = s_axis_tvalid && s_axis_tready;
        load      = s_hs && (state == ROUTE);
        drop_done = s_hs && s_axis_tlast && (state == DROP);
        drain     = out_valid && sel_ready;
    end

    // Destination of the packet in flight, captured only from its first beat.
    always_ff @(posedge aclk) begin
        if (areset) begin
            pkt_dest <= '0;
        end else if ((state == IDLE) && s_axis_tvalid) begin
            pkt_dest <= s_axis_tdest;
        end
    end

    // Holding-register occupancy: a load wins over a drain in the same cycle.
    always_ff @(posedge aclk) begin
        if (areset) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

    // Destination of the held beat; stays put while the beat waits for ready.
    always_ff @(posedge aclk) begin
        if (areset) begin
            out_dest <= '0;
        end else if (load) begin
            out_dest <= pkt_dest;
        end
    end

    // Held beat payload; qualified by out_valid so it needs no reset.
    always_ff @(posedge aclk) begin
        if (load) begin
            out_data <= s_axis_tdata;
            out_last <= s_axis_tlast;
        end
    end

    // Count each discarded packet once, on its tlast beat.
    always_ff @(posedge aclk) begin
        if (areset) begin
            drop_count <= '0;
        end else if (drop_done) begin
            drop_count <= sat_inc(drop_count);
        end
    end

    // Fan the holding register out to every channel; only the addressed one is valid.
    always_comb begin
        for (int i = 0; i < CHANNEL_NO; i++) begin
            m_axis_tdata[i]  = out_data;
            m_axis_tvalid[i] = out_valid && (out_dest == DSEL_WIDTH'(i));
            m_axis_tlast[i]  = out_last && m_axis_tvalid[i];
        end
    end

endmodule

// File: tb/tb_cross_bar_router_1xn.sv
// Directed testbench for cross_bar_router_1xn: a 4-channel instance and a
// 3-channel instance with a 2-bit drop counter. Inputs change on the falling
// edge and outputs are compared 1 time unit later.
module tb_cross_bar_router_1xn;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst4;
    logic        rst3;
    logic [31:0] s_tdata;
    logic [1:0]  s_tdest;
    logic        s_tvalid;
    logic        s_tlast;

    logic        tready4;
    logic [31:0] m_tdata4 [4];
    logic [3:0]  m_tvalid4;
    logic [3:0]  m_tlast4;
    logic [3:0]  m_tready4;
    logic [15:0] drop4;

    logic        tready3;
    logic [31:0] m_tdata3 [3];
    logic [2:0]  m_tvalid3;
    logic [2:0]  m_tlast3;
    logic [2:0]  m_tready3;
    logic [1:0]  drop3;

    int checks = 0;
    int errors = 0;

    cross_bar_router_1xn #(
        .DSEL_WIDTH(2), .CHANNEL_NO(4), .DATA_WIDTH(32), .CNT_WIDTH(16)
    ) dut4 (
        .aclk(clk), .areset(rst4),
        .s_axis_tdata(s_tdata), .s_axis_tdest(s_tdest),
        .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(tready4),
        .m_axis_tdata(m_tdata4), .m_axis_tvalid(m_tvalid4),
        .m_axis_tlast(m_tlast4), .m_axis_tready(m_tready4),
        .drop_count(drop4)
    );

    cross_bar_router_1xn #(
        .DSEL_WIDTH(2), .CHANNEL_NO(3), .DATA_WIDTH(32), .CNT_WIDTH(2)
    ) dut3 (
        .aclk(clk), .areset(rst3),
        .s_axis_tdata(s_tdata), .s_axis_tdest(s_tdest),
        .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(tready3),
        .m_axis_tdata(m_tdata3), .m_axis_tvalid(m_tvalid3),
        .m_axis_tlast(m_tlast3), .m_axis_tready(m_tready3),
        .drop_count(drop3)
    );

    task automatic test_reset();
        rst4 = 1'b1; rst3 = 1'b1;
        s_tdata = '0; s_tdest = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
        m_tready4 = 4'b1111; m_tready3 = 3'b111;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (m_tvalid4 !== 4'b0000) begin errors++; $display("FAIL reset_tvalid4 got %b expected 0000", m_tvalid4); end
        checks++; if (tready4 !== 1'b0) begin errors++; $display("FAIL reset_tready4 got %b expected 0", tready4); end
        checks++; if (drop4 !== 16'd0) begin errors++; $display("FAIL reset_drop4 got %0d expected 0", drop4); end
        checks++; if (m_tvalid3 !== 3'b000) begin errors++; $display("FAIL reset_tvalid3 got %b expected 000", m_tvalid3); end
        @(negedge clk);
        rst4 = 1'b0;
    endtask

    // 4-beat packet to ch2; tdest wiggles mid-packet and must be ignored.
    task automatic test_single_packet();
        logic        v [7];
        logic [31:0] d [7];
        logic [1:0]  t [7];
        logic        l [7];
        logic        er [7];
        logic [3:0]  ev [7];
        logic [31:0] ed [7];
        logic [3:0]  el [7];
        v  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        d  = '{32'hA0, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'h0, 32'h0};
        t  = '{2'd2, 2'd2, 2'd0, 2'd3, 2'd1, 2'd0, 2'd0};
        l  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        er = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        ev = '{4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
        ed = '{32'h0, 32'h0, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'h0};
        el = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000};
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            s_tvalid = v[k]; s_tdata = d[k]; s_tdest = t[k]; s_tlast = l[k];
            m_tready4 = 4'b1111;
            #1;
            checks++; if (tready4 !== er[k]) begin errors++; $display("FAIL pkt_tready k=%0d got %b expected %b", k, tready4, er[k]); end
            checks++; if (m_tvalid4 !== ev[k]) begin errors++; $display("FAIL pkt_tvalid k=%0d got %b expected %b", k, m_tvalid4, ev[k]); end
            if (ev[k] != 4'b0000) begin
                checks++; if (m_tdata4[2] !== ed[k]) begin errors++; $display("FAIL pkt_tdata k=%0d got %h expected %h", k, m_tdata4[2], ed[k]); end
                checks++; if (m_tlast4 !== el[k]) begin errors++; $display("FAIL pkt_tlast k=%0d got %b expected %b", k, m_tlast4, el[k]); end
            end
        end
    endtask

    // Single-beat packets to ch0,1,0,1: one bubble each, order preserved.
    task automatic test_back_to_back();
        logic        v [9];
        logic [31:0] d [9];
        logic [1:0]  t [9];
        logic        er [9];
        logic [3:0]  ev [9];
        logic [31:0] ed [9];
        v  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        d  = '{32'hB0, 32'hB0, 32'hB1, 32'hB1, 32'hB2, 32'hB2, 32'hB3, 32'hB3, 32'h0};
        t  = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0};
        er = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        ev = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0001, 4'b0000, 4'b0010};
        ed = '{32'h0, 32'h0, 32'hB0, 32'h0, 32'hB1, 32'h0, 32'hB2, 32'h0, 32'hB3};
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            s_tvalid = v[k]; s_tdata = d[k]; s_tdest = t[k]; s_tlast = v[k];
            m_tready4 = 4'b1111;
            #1;
            checks++; if (tready4 !== er[k]) begin errors++; $display("FAIL b2b_tready k=%0d got %b expected %b", k, tready4, er[k]); end
            checks++; if (m_tvalid4 !== ev[k]) begin errors++; $display("FAIL b2b_tvalid k=%0d got %b expected %b", k, m_tvalid4, ev[k]); end
            if (ev[k] != 4'b0000) begin
                checks++; if (m_tdata4[0] !== ed[k]) begin errors++; $display("FAIL b2b_tdata k=%0d got %h expected %h", k, m_tdata4[0], ed[k]); end
                checks++; if (m_tlast4 !== ev[k]) begin errors++; $display("FAIL b2b_tlast k=%0d got %b expected %b", k, m_tlast4, ev[k]); end
            end
        end
    endtask

    // 3-beat packet to ch1 with m1 stalled for 5 cycles after the first beat loads.
    task automatic test_backpressure();
        logic        v [11];
        logic [31:0] d [11];
        logic        l [11];
        logic [3:0]  rd [11];
        logic        er [11];
        logic [3:0]  ev [11];
        logic [31:0] ed [11];
        logic [3:0]  el [11];
        v  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        d  = '{32'hC0, 32'hC0, 32'hC1, 32'hC1, 32'hC1, 32'hC1, 32'hC1, 32'hC1, 32'hC2, 32'h0, 32'h0};
        l  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        rd = '{4'b1111, 4'b1111, 4'b1101, 4'b1101, 4'b1101, 4'b1101, 4'b1101, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
        er = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        ev = '{4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
        ed = '{32'h0, 32'h0, 32'hC0, 32'hC0, 32'hC0, 32'hC0, 32'hC0, 32'hC0, 32'hC1, 32'hC2, 32'h0};
        el = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            s_tvalid = v[k]; s_tdata = d[k]; s_tdest = 2'd1; s_tlast = l[k];
            m_tready4 = rd[k];
            #1;
            checks++; if (tready4 !== er[k]) begin errors++; $display("FAIL bp_tready k=%0d got %b expected %b", k, tready4, er[k]); end
            checks++; if (m_tvalid4 !== ev[k]) begin errors++; $display("FAIL bp_tvalid k=%0d got %b expected %b", k, m_tvalid4, ev[k]); end
            if (ev[k] != 4'b0000) begin
                checks++; if (m_tdata4[1] !== ed[k]) begin errors++; $display("FAIL bp_tdata k=%0d got %h expected %h", k, m_tdata4[1], ed[k]); end
                checks++; if (m_tlast4 !== el[k]) begin errors++; $display("FAIL bp_tlast k=%0d got %b expected %b", k, m_tlast4, el[k]); end
            end
        end
    endtask

    // Reset mid-packet: held beat lost, the remaining beats form a packet to ch3.
    task automatic test_reset_mid_packet();
        logic        v [9];
        logic [31:0] d [9];
        logic [1:0]  t [9];
        logic        l [9];
        logic [3:0]  rd [9];
        logic        rs [9];
        logic        er [9];
        logic [3:0]  ev [9];
        logic [31:0] ed [9];
        logic [3:0]  el [9];
        v  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        d  = '{32'hF0, 32'hF0, 32'hF1, 32'hF2, 32'hF2, 32'hF2, 32'hF3, 32'h0, 32'h0};
        t  = '{2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0};
        l  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        rd = '{4'b1111, 4'b1111, 4'b1111, 4'b1101, 4'b1101, 4'b1101, 4'b1101, 4'b1101, 4'b1111};
        rs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        er = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        ev = '{4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0000};
        ed = '{32'h0, 32'h0, 32'hF0, 32'hF1, 32'h0, 32'h0, 32'hF2, 32'hF3, 32'h0};
        el = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000};
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            s_tvalid = v[k]; s_tdata = d[k]; s_tdest = t[k]; s_tlast = l[k];
            m_tready4 = rd[k]; rst4 = rs[k];
            #1;
            checks++; if (tready4 !== er[k]) begin errors++; $display("FAIL rmp_tready k=%0d got %b expected %b", k, tready4, er[k]); end
            checks++; if (m_tvalid4 !== ev[k]) begin errors++; $display("FAIL rmp_tvalid k=%0d got %b expected %b", k, m_tvalid4, ev[k]); end
            checks++; if (drop4 !== 16'd0) begin errors++; $display("FAIL rmp_drop k=%0d got %0d expected 0", k, drop4); end
            if (ev[k] != 4'b0000) begin
                checks++; if (m_tdata4[3] !== ed[k]) begin errors++; $display("FAIL rmp_tdata k=%0d got %h expected %h", k, m_tdata4[3], ed[k]); end
                checks++; if (m_tlast4 !== el[k]) begin errors++; $display("FAIL rmp_tlast k=%0d got %b expected %b", k, m_tlast4, el[k]); end
            end
        end
    endtask

    // 3-channel instance: tdest=3 packet is swallowed and counted, next packet reaches m0.
    task automatic test_drop();
        logic        v [8];
        logic [31:0] d [8];
        logic [1:0]  t [8];
        logic        l [8];
        logic        er [8];
        logic [2:0]  ev [8];
        logic [1:0]  ec [8];
        v  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        d  = '{32'hD0, 32'hD0, 32'hD1, 32'hD2, 32'hE0, 32'hE0, 32'h0, 32'h0};
        t  = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
        l  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        er = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        ev = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000};
        ec = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1};
        @(negedge clk);
        s_tvalid = 1'b0; m_tready3 = 3'b111; rst3 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            s_tvalid = v[k]; s_tdata = d[k]; s_tdest = t[k]; s_tlast = l[k];
            #1;
            checks++; if (tready3 !== er[k]) begin errors++; $display("FAIL drop_tready k=%0d got %b expected %b", k, tready3, er[k]); end
            checks++; if (m_tvalid3 !== ev[k]) begin errors++; $display("FAIL drop_tvalid k=%0d got %b expected %b", k, m_tvalid3, ev[k]); end
            checks++; if (drop3 !== ec[k]) begin errors++; $display("FAIL drop_count k=%0d got %0d expected %0d", k, drop3, ec[k]); end
            if (ev[k] != 3'b000) begin
                checks++; if (m_tdata3[0] !== 32'hE0) begin errors++; $display("FAIL drop_tdata k=%0d got %h expected e0", k, m_tdata3[0]); end
                checks++; if (m_tlast3 !== 3'b001) begin errors++; $display("FAIL drop_tlast k=%0d got %b expected 001", k, m_tlast3); end
            end
        end
    endtask

    // Three more single-beat drops on the 2-bit counter: 1 -> 2 -> 3 -> stays 3.
    task automatic test_drop_saturate();
        logic [1:0] ec [3];
        ec = '{2'd2, 2'd3, 2'd3};
        for (int p = 0; p < 3; p++) begin
            @(negedge clk);
            s_tvalid = 1'b1; s_tdata = 32'h50 + 32'(p); s_tdest = 2'd3; s_tlast = 1'b1;
            #1;
            checks++; if (tready3 !== 1'b0) begin errors++; $display("FAIL sat_idle_tready p=%0d got %b expected 0", p, tready3); end
            @(negedge clk);
            #1;
            checks++; if (tready3 !== 1'b1) begin errors++; $display("FAIL sat_drop_tready p=%0d got %b expected 1", p, tready3); end
            @(negedge clk);
            s_tvalid = 1'b0; s_tlast = 1'b0;
            #1;
            checks++; if (drop3 !== ec[p]) begin errors++; $display("FAIL sat_count p=%0d got %0d expected %0d", p, drop3, ec[p]); end
            checks++; if (m_tvalid3 !== 3'b000) begin errors++; $display("FAIL sat_tvalid p=%0d got %b expected 000", p, m_tvalid3); end
        end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_packet();
        test_drop();
        test_drop_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
